// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column sweep, press/release debounce with ghost
// rejection, and a small key-event FIFO handed out over valid/ready.
module keypad_scanner #(
    parameter int NROWS      = 4,
    parameter int NCOLS      = 4,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(NROWS * NCOLS)
) (
    input  logic             slowclk,
    input  logic             reset,
    input  logic [NROWS-1:0] rows,
    output logic [NCOLS-1:0] cols,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [CW-1:0]    key_code,
    output logic             key_held,
    output logic             overflow
);
    localparam int CNTW = $clog2(DEBOUNCE + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [NCOLS-1:0] COL_HOME = NCOLS'(1) << (NCOLS - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t          state_reg;
    logic [CNTW-1:0] cnt_reg;
    logic [NROWS-1:0] row_latch_reg;
    logic [CW-1:0]   code_latch_reg;

    logic [CW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg, rd_ptr_inc;
    logic [LW-1:0]   level_reg, level_next;
    logic [CW-1:0]   head_next;

    logic            rows_zero, rows_single, rows_match, cols_onehot, cnt_last;
    logic            push, pop, full, push_ok;
    logic [CW-1:0]   scan_code;
    logic [NCOLS-1:0] cols_rot;

    assign rows_zero   = (rows == '0);
    assign rows_single = !rows_zero && ((rows & (rows - NROWS'(1))) == '0);
    assign rows_match  = (rows == row_latch_reg);
    assign cols_onehot = (cols != '0) && ((cols & (cols - NCOLS'(1))) == '0);
    assign cnt_last    = (cnt_reg == CNTW'(DEBOUNCE - 1));
    // An illegal column pattern snaps back to the home column instead of rotating.
    assign cols_rot    = cols_onehot ? {cols[0], cols[NCOLS-1:1]} : COL_HOME;

    always_comb begin
        scan_code = '0;
        for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < NCOLS; c++) begin
                if (rows[r] && cols[c]) begin
                    scan_code = CW'(r * NCOLS + c);
                end
            end
        end
    end

    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            state_reg      <= SCAN;
            cols           <= COL_HOME;
            cnt_reg        <= '0;
            row_latch_reg  <= '0;
            code_latch_reg <= '0;
            key_held       <= 1'b0;
        end else begin
            case (state_reg)
                SCAN: begin
                    if (rows_single) begin
                        row_latch_reg  <= rows;
                        code_latch_reg <= scan_code;
                        cnt_reg        <= CNTW'(1);
                        state_reg      <= PRESS_DB;
                    end else begin
                        cols <= cols_rot;
                    end
                end
                PRESS_DB: begin
                    if (rows_match) begin
                        cnt_reg <= cnt_reg + CNTW'(1);
                        if (cnt_last) begin
                            state_reg <= HELD;
                            key_held  <= 1'b1;
                        end
                    end else begin
                        state_reg <= SCAN;
                    end
                end
                HELD: begin
                    if (rows_zero) begin
                        cnt_reg   <= CNTW'(1);
                        state_reg <= RELEASE_DB;
                        key_held  <= 1'b0;
                    end
                end
                default: begin
                    if (rows_zero) begin
                        cnt_reg <= cnt_reg + CNTW'(1);
                        if (cnt_last) begin
                            state_reg <= SCAN;
                            cols      <= cols_rot;
                        end
                    end else begin
                        state_reg <= HELD;
                        key_held  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign push       = (state_reg == PRESS_DB) && rows_match && cnt_last;
    assign pop        = key_valid && key_ready;
    assign full       = (level_reg == LW'(FIFO_DEPTH));
    assign push_ok    = push && (!full || pop);
    assign rd_ptr_inc = rd_ptr_reg + PW'(1);
    assign level_next = level_reg + LW'(push_ok) - LW'(pop);

    // key_code is a head register so the next entry is ready the cycle after a pop.
    always_comb begin
        head_next = key_code;
        if (pop) begin
            if (level_reg > LW'(1)) begin
                head_next = mem[rd_ptr_inc];
            end else if (push_ok) begin
                head_next = code_latch_reg;
            end
        end else if (level_reg == '0 && push_ok) begin
            head_next = code_latch_reg;
        end
    end

    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            level_reg <= level_next;
            key_valid <= (level_next != '0);
            key_code  <= head_next;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge slowclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= code_latch_reg;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from cols, expected
// key codes are queued at press time and compared when the scanner hands them out.
module tb_keypad_scanner;
    localparam int NROWS = 4;
    localparam int NCOLS = 4;
    localparam int DEBOUNCE = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CW = $clog2(NROWS * NCOLS);

    logic             slowclk;
    logic             reset;
    logic [NROWS-1:0] rows;
    logic [NCOLS-1:0] cols;
    logic             key_valid;
    logic             key_ready;
    logic [CW-1:0]    key_code;
    logic             key_held;
    logic             overflow;

    logic             use_model;
    logic             key_down;
    int               kr, kc;
    logic [NROWS-1:0] rows_raw;

    int               n_checks = 0;
    int               n_pass = 0;
    int               sb[$];

    keypad_scanner #(
        .NROWS(NROWS), .NCOLS(NCOLS), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .slowclk(slowclk), .reset(reset), .rows(rows), .cols(cols),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_held(key_held), .overflow(overflow)
    );

    initial slowclk = 1'b0;
    always #5 slowclk = ~slowclk;

    // A pressed key connects its row to its column only while that column is driven.
    always_comb begin
        rows = rows_raw;
        if (use_model) begin
            rows = (key_down && cols[kc]) ? (NROWS'(1) << kr) : '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge slowclk);
        #1;
    endtask

    task automatic wait_col(input int c);
        for (int i = 0; i < 2 * NCOLS; i++) begin
            if (cols[c]) return;
            tick();
        end
        check("wait_col_timeout", 32'(cols), 32'(1) << c);
    endtask

    // Hold a key from an idle scan until its press has been accepted.
    task automatic press(input int r, input int c);
        kr = r;
        kc = c;
        key_down = 1'b1;
        wait_col(c);
        repeat (DEBOUNCE) tick();
    endtask

    task automatic release_key();
        key_down = 1'b0;
        repeat (DEBOUNCE) tick();
    endtask

    task automatic take();
        if (!key_valid || sb.size() == 0) begin
            check("take_ready", {31'd0, key_valid}, 32'(sb.size() != 0));
            return;
        end
        check("take_code", 32'(key_code), 32'(sb.pop_front()));
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    initial begin
        int hits;
        int codes_r[5];
        int codes_c[5];

        use_model = 1'b1;
        key_down  = 1'b0;
        kr = 0;
        kc = 0;
        rows_raw  = '0;
        key_ready = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge slowclk);
        #1 reset = 1'b0;

        // reset state and idle sweep
        check("rst_cols", 32'(cols), 32'b1000);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_code", 32'(key_code), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_ovf", 32'(overflow), 0);
        tick(); check("idle_c1", 32'(cols), 32'b0100);
        tick(); check("idle_c2", 32'(cols), 32'b0010);
        tick(); check("idle_c3", 32'(cols), 32'b0001);
        tick(); check("idle_c4", 32'(cols), 32'b1000);

        // clean press at row 2, column 1 with exact latency
        kr = 2; kc = 1; key_down = 1'b1;
        sb.push_back(2 * NCOLS + 1);
        wait_col(1);
        tick();
        check("press_e0_valid", 32'(key_valid), 0);
        check("press_e0_cols", 32'(cols), 32'b0010);
        tick(); tick();
        check("press_e2_valid", 32'(key_valid), 0);
        tick();
        check("press_valid", 32'(key_valid), 1);
        check("press_held", 32'(key_held), 1);
        check("press_cols", 32'(cols), 32'b0010);
        take();
        check("press_popped", 32'(key_valid), 0);
        key_ready = 1'b1;
        hits = 0;
        repeat (50) begin
            tick();
            if (key_valid) hits++;
        end
        key_ready = 1'b0;
        check("hold_no_repeat", 32'(hits), 0);
        check("hold_cols", 32'(cols), 32'b0010);
        key_down = 1'b0;
        tick();
        check("rel_held", 32'(key_held), 0);
        tick(); tick();
        check("rel_frozen", 32'(cols), 32'b0010);
        tick();
        check("rel_rotate", 32'(cols), 32'b0001);

        // bounce shorter than the debounce window
        kr = 0; kc = 2; key_down = 1'b1;
        wait_col(2);
        tick(); tick();
        key_down = 1'b0;
        tick();
        check("bounce_held", 32'(key_held), 0);
        check("bounce_cols", 32'(cols), 32'b0100);
        tick();
        check("bounce_rotate", 32'(cols), 32'b0010);
        check("bounce_valid", 32'(key_valid), 0);

        // two rows at once in one column is a ghost pattern
        use_model = 1'b0;
        rows_raw = '0;
        wait_col(3);
        rows_raw = 4'b0110;
        tick(); check("ghost_c1", 32'(cols), 32'b0100);
        tick(); check("ghost_c2", 32'(cols), 32'b0010);
        tick(); check("ghost_c3", 32'(cols), 32'b0001);
        tick(); check("ghost_c4", 32'(cols), 32'b1000);
        check("ghost_valid", 32'(key_valid), 0);
        rows_raw = '0;
        use_model = 1'b1;

        // release glitch during HELD yields no second event
        sb.push_back(1 * NCOLS + 3);
        press(1, 3);
        check("glitch_held", 32'(key_held), 1);
        key_down = 1'b0;
        tick(); tick();
        check("glitch_rel_db", 32'(key_held), 0);
        key_down = 1'b1;
        tick();
        check("glitch_back", 32'(key_held), 1);
        repeat (3) tick();
        take();
        check("glitch_single", 32'(key_valid), 0);
        release_key();

        // fill the queue, then a fifth push lands on the same edge as a pop
        codes_r = '{0, 1, 3, 2, 0};
        codes_c = '{0, 2, 3, 0, 3};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(codes_r[i] * NCOLS + codes_c[i]);
            press(codes_r[i], codes_c[i]);
            release_key();
        end
        check("full_valid", 32'(key_valid), 1);
        kr = codes_r[4]; kc = codes_c[4]; key_down = 1'b1;
        wait_col(kc);
        repeat (DEBOUNCE - 1) tick();
        check("coin_head", 32'(key_code), 32'(sb.pop_front()));
        sb.push_back(codes_r[4] * NCOLS + codes_c[4]);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("coin_ovf", 32'(overflow), 0);
        release_key();
        for (int i = 0; i < 4; i++) take();
        check("coin_drained", 32'(key_valid), 0);

        // overflow: five presses with the consumer stalled
        codes_r = '{3, 0, 2, 1, 3};
        codes_c = '{0, 2, 3, 0, 2};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(codes_r[i] * NCOLS + codes_c[i]);
            press(codes_r[i], codes_c[i]);
            release_key();
            if (i == 3) check("ovf_before", 32'(overflow), 0);
        end
        check("ovf_set", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) take();
        check("ovf_drained", 32'(key_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // asynchronous reset in the middle of a debounce with events queued
        sb.delete();
        press(0, 1);
        release_key();
        press(2, 2);
        release_key();
        check("pre_rst_valid", 32'(key_valid), 1);
        kr = 1; kc = 1; key_down = 1'b1;
        wait_col(1);
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        check("arst_cols", 32'(cols), 32'b1000);
        check("arst_valid", 32'(key_valid), 0);
        check("arst_code", 32'(key_code), 0);
        check("arst_held", 32'(key_held), 0);
        check("arst_ovf", 32'(overflow), 0);
        key_down = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_valid", 32'(key_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner that supersedes the fixed 4x4 scanner in the keypad front end. It drives a one-hot column scan, debounces both press and release over a configurable number of slowclk samples, and rejects multi-row ghost patterns. Each accepted key press is queued in a small event FIFO and handed to the game logic over a valid/ready interface, with a sticky overflow flag for dropped events. It sits between the board keypad pins and the Tetris control logic, clocked by the divided slowclk.

## Interface
Parameters:
- NROWS, 4, number of row inputs (>=1)
- NCOLS, 4, number of column outputs (>=2)
- DEBOUNCE, 4, consecutive matching samples required to accept a press or release (>=2)
- FIFO_DEPTH, 4, key-event queue depth (power of two, >=2)
- CW, $clog2(NROWS*NCOLS), key code width (derived)

Ports:
- slowclk  in  1  scan clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clock slowclk
- rows  in  NROWS  row sense lines, active-high
- cols  out  NCOLS  one-hot column drive
- key_valid  out  1  FIFO non-empty; key_code is valid
- key_ready  in  1  consumer accepts key_code when key_valid is also high
- key_code  out  CW  head-of-queue code = row_index*NCOLS + col_index
- key_held  out  1  high while in HELD state
- overflow  out  1  sticky: an accepted press was dropped because the FIFO was full

## Operation
- row_index/col_index are the bit positions of the asserted row bit and the asserted cols bit (bit 0 = index 0).
- Scan FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN: if rows==0 or rows has >1 bit set, rotate cols right one position (bit NCOLS-1 -> ... -> bit 0 -> bit NCOLS-1). Exactly one bit set: latch rows pattern and code, set cnt=1, go to PRESS_DB, and hold cols.
- PRESS_DB: cols frozen. rows == latched pattern: cnt++; when cnt would reach DEBOUNCE, push the code and go to HELD. Any mismatch: go to SCAN without rotating (re-evaluated next edge).
- HELD: cols frozen. rows!=0: stay. rows==0: cnt=1, go to RELEASE_DB.
- RELEASE_DB: rows==0: cnt++; when cnt reaches DEBOUNCE, go to SCAN and rotate cols. rows!=0: go to HELD (no new event).
- Only one event is produced per press, regardless of hold length; there is no auto-repeat.
- FIFO: push on PRESS_DB completion; pop when key_valid && key_ready. key_code = head entry (register or mem read, no bubble).
- Push while full with no pop: event dropped, overflow <= 1 (cleared only by reset). Push and pop on the same edge while full: both succeed, no overflow. Pop when empty is impossible (key_valid low).
- A cols value that is not one-hot (never legal) recovers to bit NCOLS-1 on the next rotate.

## Timing
- Reset values: cols = 1<<(NCOLS-1), state SCAN, cnt 0, FIFO empty, key_valid 0, key_code 0, key_held 0, overflow 0.
- Reset mid-operation drops queued events and in-flight debounce immediately (async).
- Press latency: if SCAN samples a single-row press at edge E0, the push occurs at edge E0+DEBOUNCE-1. key_valid rises after that edge when the FIFO was empty.
- key_held rises after edge E0+DEBOUNCE-1 and falls after the edge that enters RELEASE_DB.
- Release: scanning resumes (cols rotates) at the DEBOUNCE-th consecutive zero sample after leaving HELD.
- Scan period with no key pressed: NCOLS slowclk cycles per full sweep.
- key_code and key_valid are registered outputs, with no combinational path from rows or key_ready.

## Test plan
- Reset, idle: rows=0 -> cols sequence 1000,0100,0010,0001,1000 on successive edges; key_valid=0, overflow=0.
- Clean press (defaults): rows=0100 held while cols=0010 -> after 4 matching samples, key_valid=1, key_code=9 (2*4+1), key_held=1, cols frozen at 0010. key_ready=1 -> key_valid=0 next edge, and only one event is produced for a 50-cycle hold.
- Bounce: rows=0001 for 2 cycles then 0 -> no event, FSM back in SCAN. Release glitch of rows=0 for 2 cycles during HELD -> returns to HELD, no second event.
- Ghost rejection: rows=0110 -> cols keeps rotating, no event.
- Overflow: key_ready=0, 5 distinct clean presses -> first 4 codes queued in order, overflow=1. Then drain with key_ready=1 -> 4 codes in press order. A 5th press on the full FIFO coinciding with a pop -> accepted, no further overflow change.
- Async reset asserted mid-PRESS_DB with 2 events queued -> all outputs at reset values before the next slowclk edge.
